serial_to_parallel_rx: RTL and testbench

// - Receive end of the serial link. Sits directly downstream of the parallel-to-serial

---
 rtl/serial_to_parallel_rx_pkg.sv | 17 +
 rtl/serial_to_parallel_rx_hold_reg.sv | 58 +++++
 rtl/serial_to_parallel_rx.sv | 118 +++++++++++
 tb/tb_serial_to_parallel_rx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_to_parallel_rx_pkg.sv
// Shared definitions for the serial link transmitter and receiver:
// default word width, FSM state encoding and bit-counter width helper.
package serial_to_parallel_rx_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_t;

  // Bit counter must hold 0..width-1; never narrower than one bit.
  function automatic int bitcnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_to_parallel_rx_hold_reg.sv
// Single-entry valid/ready holding register for received words, with sticky
// overrun detection and a wrapping count of accepted words.
module rx_hold_reg
  import serial_to_parallel_rx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  input  logic             i_err_clr,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrun,
  output logic [CNT_W-1:0] o_word_cnt
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;
  logic [CNT_W-1:0] r_word_cnt;
  logic             w_drop;

  // A completed word is lost only if the previous one is still waiting.
  assign w_drop = i_load && r_valid && !i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      if (i_load && !w_drop) begin
        r_data     <= i_data;
        r_valid    <= 1'b1;
        r_word_cnt <= r_word_cnt + 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end

      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (i_err_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_data     = r_data;
  assign o_valid    = r_valid;
  assign o_overrun  = r_overrun;
  assign o_word_cnt = r_word_cnt;

endmodule

// File: rtl/serial_to_parallel_rx.sv
// Serial link receiver: reassembles MSB-first WIDTH-bit frames qualified by vi,
// flags framing errors, and hands words to a valid/ready holding register.
module serial_to_parallel_rx
  import serial_to_parallel_rx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 8
) (
  input  logic             ck,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             vi,
  input  logic             done_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  input  logic             err_clr,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int BCW = bitcnt_w(WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  rx_state_t        r_state;
  rx_state_t        w_state_nxt;
  logic [BCW-1:0]   r_bit_cnt;
  logic [BCW-1:0]   w_bit_cnt_nxt;
  logic [WIDTH-2:0] r_sr;
  logic [WIDTH-2:0] w_sr_nxt;
  logic [WIDTH-1:0] w_word;
  logic             w_complete;
  logic             w_abort;
  logic             r_frame_err;

  assign w_word = {r_sr, ser_in};

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_sr      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_sr      <= w_sr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_sr_nxt      = r_sr;
    w_complete    = 1'b0;
    w_abort       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (vi) begin
          w_state_nxt   = ST_SHIFT;
          w_sr_nxt      = '0;
          w_sr_nxt[0]   = ser_in;
          w_bit_cnt_nxt = BCW'(1);
        end
      end
      ST_SHIFT: begin
        // done_in on the final bit is a normal end of transmission, not an error.
        if (!vi || (done_in && (r_bit_cnt < LAST_BIT))) begin
          w_abort       = 1'b1;
          w_state_nxt   = ST_IDLE;
          w_bit_cnt_nxt = '0;
        end else if (r_bit_cnt == LAST_BIT) begin
          w_complete    = 1'b1;
          w_state_nxt   = ST_IDLE;
          w_bit_cnt_nxt = '0;
        end else begin
          w_sr_nxt      = w_word[WIDTH-2:0];
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_bit_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      r_frame_err <= 1'b0;
    end else if (w_abort) begin
      r_frame_err <= 1'b1;
    end else if (err_clr) begin
      r_frame_err <= 1'b0;
    end
  end

  rx_hold_reg #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_hold (
    .i_clk      (ck),
    .i_rst_n    (reset),
    .i_load     (w_complete),
    .i_data     (w_word),
    .i_ready    (data_ready),
    .i_err_clr  (err_clr),
    .o_data     (data_out),
    .o_valid    (data_valid),
    .o_overrun  (overrun),
    .o_word_cnt (word_cnt)
  );

  assign busy      = (r_state == ST_SHIFT);
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Self-checking bench: directed frames with literal expectations plus a random
// run, all compared every cycle against a queue-based behavioural model.
module tb_serial_to_parallel_rx;

  localparam int W = 8;

  logic ck = 1'b0;
  logic reset = 1'b0;
  logic ser_in = 1'b0, vi = 1'b0, done_in = 1'b0, data_ready = 1'b0, err_clr = 1'b0;

  logic [W-1:0] d_data, e_data;
  logic         d_valid, d_busy, d_ferr, d_ovr;
  logic         e_valid, e_busy, e_ferr, e_ovr;
  logic [7:0]   d_cnt;
  logic [1:0]   e_cnt;

  int n_checks = 0;
  int n_fail = 0;

  always #5 ck = ~ck;

  serial_to_parallel_rx #(.WIDTH(W), .CNT_W(8)) dut (
    .ck(ck), .reset(reset), .ser_in(ser_in), .vi(vi), .done_in(done_in),
    .data_out(d_data), .data_valid(d_valid), .data_ready(data_ready),
    .busy(d_busy), .frame_err(d_ferr), .overrun(d_ovr), .err_clr(err_clr),
    .word_cnt(d_cnt)
  );

  serial_to_parallel_rx #(.WIDTH(W), .CNT_W(2)) dut_w2 (
    .ck(ck), .reset(reset), .ser_in(ser_in), .vi(vi), .done_in(done_in),
    .data_out(e_data), .data_valid(e_valid), .data_ready(data_ready),
    .busy(e_busy), .frame_err(e_ferr), .overrun(e_ovr), .err_clr(err_clr),
    .word_cnt(e_cnt)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  // Behavioural model: bits of the frame in flight, the held word, flags and total words loaded.
  int       m_bits[$];
  logic [W-1:0] m_data = '0;
  bit       m_valid = 0, m_ferr = 0, m_ovr = 0;
  int       m_cnt = 0;

  task automatic model_reset();
    m_bits.delete();
    m_data = '0; m_valid = 0; m_ferr = 0; m_ovr = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit complete = 0, ferr_new = 0, ovr_new = 0;
    int word = 0;
    if (m_bits.size() == 0) begin
      if (vi) m_bits.push_back(int'(ser_in));
    end else if (!vi || (done_in && m_bits.size() < W - 1)) begin
      m_bits.delete();
      ferr_new = 1;
    end else begin
      m_bits.push_back(int'(ser_in));
      if (m_bits.size() == W) begin
        foreach (m_bits[i]) word = word * 2 + m_bits[i];
        complete = 1;
        m_bits.delete();
      end
    end
    if (complete) begin
      if (m_valid && !data_ready) ovr_new = 1;
      else begin
        m_data = W'(word);
        m_valid = 1;
        m_cnt++;
      end
    end else if (m_valid && data_ready) begin
      m_valid = 0;
    end
    m_ferr = ferr_new ? 1'b1 : (err_clr ? 1'b0 : m_ferr);
    m_ovr  = ovr_new  ? 1'b1 : (err_clr ? 1'b0 : m_ovr);
  endtask

  always @(posedge ck or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  always @(negedge ck) begin
    if (reset) begin
      chk("data_out", 32'(d_data), 32'(m_data));
      chk("data_valid", 32'(d_valid), 32'(m_valid));
      chk("busy", 32'(d_busy), 32'(m_bits.size() > 0));
      chk("frame_err", 32'(d_ferr), 32'(m_ferr));
      chk("overrun", 32'(d_ovr), 32'(m_ovr));
      chk("word_cnt", 32'(d_cnt), 32'(m_cnt & 255));
      chk("w2_data_out", 32'(e_data), 32'(m_data));
      chk("w2_data_valid", 32'(e_valid), 32'(m_valid));
      chk("w2_overrun", 32'(e_ovr), 32'(m_ovr));
      chk("w2_word_cnt", 32'(e_cnt), 32'(m_cnt & 3));
    end
  end

  // Called at a falling edge: drive inputs, advance to the next falling edge.
  task automatic cycle(input logic v, input logic s, input logic d, input logic r, input logic c);
    vi = v; ser_in = s; done_in = d; data_ready = r; err_clr = c;
    @(negedge ck);
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic rdy, input logic clr_last);
    logic [W-1:0] word;
    word = w;
    for (int i = W - 1; i >= 0; i--)
      cycle(1'b1, word[i], 1'b0, rdy, (i == 0) ? clr_last : 1'b0);
  endtask

  task automatic do_reset();
    vi = 0; ser_in = 0; done_in = 0; data_ready = 0; err_clr = 0;
    reset = 1'b0;
    repeat (2) @(negedge ck);
    reset = 1'b1;
    @(negedge ck);
  endtask

  initial begin
    logic [W-1:0] ff_word;
    int exp_wrap[5];
    exp_wrap = '{1, 2, 3, 0, 1};

    do_reset();
    chk("rst_data_out", 32'(d_data), 32'h0);
    chk("rst_valid", 32'(d_valid), 32'h0);
    chk("rst_busy", 32'(d_busy), 32'h0);
    chk("rst_flags", 32'({d_ferr, d_ovr}), 32'h0);
    chk("rst_word_cnt", 32'(d_cnt), 32'h0);

    // Single frame 0xA5, consumer ready.
    send_frame(8'hA5, 1'b1, 1'b0);
    chk("a5_data", 32'(d_data), 32'hA5);
    chk("a5_valid", 32'(d_valid), 32'h1);
    chk("a5_cnt", 32'(d_cnt), 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("a5_valid_one_cycle", 32'(d_valid), 32'h0);

    // Back-to-back with consumer stalled: second word overruns.
    do_reset();
    send_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b0);
    chk("ovr_data_held", 32'(d_data), 32'h3C);
    chk("ovr_flag", 32'(d_ovr), 32'h1);
    chk("ovr_cnt", 32'(d_cnt), 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovr_consumed", 32'(d_valid), 32'h0);

    // Back-to-back with consumer ready.
    do_reset();
    send_frame(8'h3C, 1'b1, 1'b0);
    chk("b2b_first", 32'(d_data), 32'h3C);
    send_frame(8'hC3, 1'b1, 1'b0);
    chk("b2b_second", 32'(d_data), 32'hC3);
    chk("b2b_valid", 32'(d_valid), 32'h1);
    chk("b2b_no_ovr", 32'(d_ovr), 32'h0);
    chk("b2b_cnt", 32'(d_cnt), 32'h2);

    // vi drops after 5 bits, then a clean frame, then err_clr.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ferr_set", 32'(d_ferr), 32'h1);
    chk("ferr_no_valid", 32'(d_valid), 32'h0);
    send_frame(8'h81, 1'b1, 1'b0);
    chk("ferr_then_81", 32'(d_data), 32'h81);
    chk("ferr_then_81_valid", 32'(d_valid), 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("ferr_cleared", 32'(d_ferr), 32'h0);

    // done_in mid-frame is a framing error.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("done_mid_ferr", 32'(d_ferr), 32'h1);
    chk("done_mid_idle", 32'(d_busy), 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Async reset in the middle of frame 0xFF.
    send_frame(8'h81, 1'b0, 1'b0);
    ff_word = 8'hFF;
    for (int i = 0; i < 4; i++) cycle(1'b1, ff_word[W-1-i], 1'b0, 1'b0, 1'b0);
    chk("pre_rst_busy", 32'(d_busy), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(d_busy), 32'h0);
    chk("mid_rst_valid", 32'(d_valid), 32'h0);
    chk("mid_rst_data", 32'(d_data), 32'h0);
    chk("mid_rst_flags", 32'({d_ferr, d_ovr}), 32'h0);
    chk("mid_rst_cnt", 32'(d_cnt), 32'h0);
    vi = 0;
    @(negedge ck);
    reset = 1'b1;
    @(negedge ck);
    send_frame(8'h5A, 1'b1, 1'b0);
    chk("post_rst_5a", 32'(d_data), 32'h5A);
    chk("post_rst_flags", 32'({d_ferr, d_ovr}), 32'h0);

    // Counter wrap on the 2-bit instance, then overrun coinciding with err_clr.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send_frame(W'($urandom), 1'b1, 1'b0);
      chk("wrap_cnt", 32'(e_cnt), 32'(exp_wrap[k]));
    end
    send_frame(8'h77, 1'b0, 1'b1);
    chk("clr_vs_ovr", 32'(e_ovr), 32'h1);
    chk("clr_vs_ovr_main", 32'(d_ovr), 32'h1);
    chk("clr_vs_ovr_cnt", 32'(d_cnt), 32'h5);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_cleared", 32'(d_ovr), 32'h0);

    // Random traffic, checked by the per-cycle model compare.
    do_reset();
    for (int n = 0; n < 4000; n++)
      cycle($urandom_range(0, 99) < 90, 1'($urandom), $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 4);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
